instr_byte_queue: RTL

Byte-granular prefetch queue directly upstream of the x86 `decoder`. Accepts 32-bit little-endian words from the fetch/memory side and always presents the next 4 instruction bytes, aligned to the current instruction start, as a 32-bit window. The decoder consumes 1–4 bytes per cycle. The queue tracks the byte address of the window head and supports a flush/redirect for branches.

---
 rtl/x86_fetch_pkg.sv | 10 +
 rtl/instr_byte_queue.sv | 108 ++++++++++
 2 files changed

// File: rtl/x86_fetch_pkg.sv
// Shared constants and types for the x86 fetch front end (prefetch queue and decoder).
package x86_fetch_pkg;

    localparam int BYTE_W          = 8;
    localparam int MAX_INSTR_BYTES = 4;
    localparam int FETCH_BYTES     = 4;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage : x86_fetch_pkg

// File: rtl/instr_byte_queue.sv
// Byte-granular prefetch queue: accepts 32-bit fetch words and presents the next
// four instruction bytes, aligned to the current instruction start, to the decoder.
module instr_byte_queue
    import x86_fetch_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [31:0]                i_mem_data,
    input  logic                       i_mem_valid,
    output logic                       o_mem_ready,
    output logic [31:0]                o_window,
    output logic                       o_ready,
    input  logic [2:0]                 i_consume_len,
    input  logic                       i_flush,
    input  logic [31:0]                i_flush_pc,
    output logic [31:0]                o_pc,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    byte_t           mem_r [DEPTH];
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic [31:0]     pc_r;
    logic            error_r;

    logic [CW-1:0]   free_s;
    logic            mem_ready_s;
    logic            push_s;
    logic            consume_s;
    logic            illegal_s;
    logic [CW-1:0]   count_nxt_s;
    logic [31:0]     window_s;

    // Push/consume qualification, all decided on the pre-update count.
    always_comb begin
        free_s      = CW'(DEPTH) - count_r;
        mem_ready_s = (free_s >= CW'(FETCH_BYTES));
        push_s      = i_mem_valid && mem_ready_s;
        if ((i_consume_len != 3'd0) &&
            (i_consume_len <= 3'(MAX_INSTR_BYTES)) &&
            (CW'(i_consume_len) <= count_r)) begin
            consume_s = 1'b1;
        end else begin
            consume_s = 1'b0;
        end
        illegal_s   = (i_consume_len != 3'd0) && !consume_s;
        count_nxt_s = count_r
                    + (push_s    ? CW'(FETCH_BYTES)   : CW'(0))
                    - (consume_s ? CW'(i_consume_len) : CW'(0));
    end

    // Head-aligned window; bytes beyond count are stale storage.
    always_comb begin
        window_s = 32'h0000_0000;
        for (int k = 0; k < MAX_INSTR_BYTES; k++) begin
            window_s[BYTE_W*k +: BYTE_W] = mem_r[head_r + PW'(k)];
        end
    end

    // Queue state: reset beats flush, flush beats push and consume.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            pc_r    <= RESET_PC;
            error_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (i_flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            pc_r    <= i_flush_pc;
            error_r <= 1'b0;
        end else begin
            if (push_s) begin
                for (int k = 0; k < FETCH_BYTES; k++) begin
                    mem_r[tail_r + PW'(k)] <= i_mem_data[BYTE_W*k +: BYTE_W];
                end
                tail_r <= tail_r + PW'(FETCH_BYTES);
            end
            if (consume_s) begin
                head_r <= head_r + PW'(i_consume_len);
                pc_r   <= pc_r + 32'(i_consume_len);
            end
            count_r <= count_nxt_s;
            error_r <= illegal_s;
        end
    end

    assign o_mem_ready = mem_ready_s;
    assign o_window    = window_s;
    assign o_ready     = (count_r >= CW'(MAX_INSTR_BYTES));
    assign o_pc        = pc_r;
    assign o_count     = count_r;
    assign o_error     = error_r;

endmodule : instr_byte_queue
